light_stand_ctrl: RTL and testbench

- Brightness controller for the light stand.
- Consumes one-cycle release pulses from the debounced button blocks and steps through five brightness levels (OFF, L1–L4).
- Drives a glitch-free PWM output whose duty is updated only at period boundaries.
- Turns the light off automatically after a programmable number of PWM periods without any button activity.

---
 rtl/light_stand_ctrl.sv | 122 ++++++++++++
 tb/tb_light_stand_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/light_stand_ctrl.sv
// Light stand brightness controller: five-level FSM (OFF, L1..L4) driving a
// glitch-free PWM whose duty is latched at period boundaries, with idle auto-off.
module light_stand_ctrl #(
   parameter int unsigned PWM_PERIOD       = 100,
   parameter int unsigned DUTY_L1          = 25,
   parameter int unsigned DUTY_L2          = 50,
   parameter int unsigned DUTY_L3          = 75,
   parameter int unsigned DUTY_L4          = 100,
   parameter int unsigned AUTO_OFF_PERIODS = 50_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_mode,
   input  logic       i_btn_off,
   output logic       o_pwm,
   output logic [2:0] o_level,
   output logic       o_period_tick
);

   typedef enum logic [2:0] {
      LVL_OFF = 3'd0,
      LVL_1   = 3'd1,
      LVL_2   = 3'd2,
      LVL_3   = 3'd3,
      LVL_4   = 3'd4
   } level_e;

   localparam logic [15:0] PWM_LAST = 16'(PWM_PERIOD - 1);
   localparam logic [31:0] AUTO_OFF = AUTO_OFF_PERIODS;
   localparam logic [31:0] IDLE_MAX = 32'hFFFF_FFFF;

   // Duties at or above the period are clamped to the period so the counter
   // compare stays true for every count and the output never drops at wrap.
   localparam logic [15:0] DUTY1_C = (DUTY_L1 >= PWM_PERIOD) ? 16'(PWM_PERIOD) : 16'(DUTY_L1);
   localparam logic [15:0] DUTY2_C = (DUTY_L2 >= PWM_PERIOD) ? 16'(PWM_PERIOD) : 16'(DUTY_L2);
   localparam logic [15:0] DUTY3_C = (DUTY_L3 >= PWM_PERIOD) ? 16'(PWM_PERIOD) : 16'(DUTY_L3);
   localparam logic [15:0] DUTY4_C = (DUTY_L4 >= PWM_PERIOD) ? 16'(PWM_PERIOD) : 16'(DUTY_L4);

   level_e      level_q,   level_d;
   logic [15:0] pwm_cnt_q, pwm_cnt_d;
   logic [15:0] duty_q,    duty_d;
   logic [31:0] idle_q,    idle_d;
   logic        pwm_q,     pwm_d;
   logic        tick_q,    tick_d;

   logic        wrap;
   logic        anyBtn;
   logic        expire;
   logic        autoOff;
   level_e      levelNext;
   logic [15:0] levelDuty;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         level_q   <= LVL_OFF;
         pwm_cnt_q <= 16'd0;
         duty_q    <= 16'd0;
         idle_q    <= 32'd0;
         pwm_q     <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         level_q   <= level_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         idle_q    <= idle_d;
         pwm_q     <= pwm_d;
         tick_q    <= tick_d;
      end
   end

   always_comb begin
      levelNext = LVL_OFF;
      levelDuty = 16'd0;
      case (level_q)
         LVL_OFF: begin levelNext = LVL_1;   levelDuty = 16'd0;   end
         LVL_1:   begin levelNext = LVL_2;   levelDuty = DUTY1_C; end
         LVL_2:   begin levelNext = LVL_3;   levelDuty = DUTY2_C; end
         LVL_3:   begin levelNext = LVL_4;   levelDuty = DUTY3_C; end
         LVL_4:   begin levelNext = LVL_OFF; levelDuty = DUTY4_C; end
         default: begin levelNext = LVL_OFF; levelDuty = 16'd0;   end
      endcase
   end

   // Auto-off fires at a wrap once idle_q already holds the full count of idle
   // wraps; any button pulse in that same cycle takes priority over it.
   always_comb begin
      wrap    = (pwm_cnt_q == PWM_LAST);
      anyBtn  = i_btn_mode | i_btn_off;
      expire  = (AUTO_OFF != 32'd0) && wrap && (level_q != LVL_OFF) && (idle_q >= AUTO_OFF);
      autoOff = expire && !anyBtn;

      pwm_cnt_d = wrap ? 16'd0 : pwm_cnt_q + 16'd1;
      tick_d    = wrap;
      pwm_d     = (pwm_cnt_q < duty_q);

      level_d = level_q;
      if (i_btn_off || autoOff) begin
         level_d = LVL_OFF;
      end else if (i_btn_mode) begin
         level_d = levelNext;
      end

      duty_d = duty_q;
      if (i_btn_off || autoOff) begin
         duty_d = 16'd0;
      end else if (wrap) begin
         duty_d = levelDuty;
      end

      idle_d = idle_q;
      if (anyBtn || (level_q == LVL_OFF) || autoOff) begin
         idle_d = 32'd0;
      end else if (wrap && (idle_q != IDLE_MAX)) begin
         idle_d = idle_q + 32'd1;
      end
   end

   assign o_pwm         = pwm_q;
   assign o_level       = level_q;
   assign o_period_tick = tick_q;

endmodule

// File: tb/tb_light_stand_ctrl.sv
// Directed bench for light_stand_ctrl with a 10-clock period, duties 2/5/7/10
// and auto-off after 3 idle periods.
module tb_light_stand_ctrl;

   logic       clk;
   logic       reset;
   logic       btnMode;
   logic       btnOff;
   logic       pwm;
   logic [2:0] level;
   logic       periodTick;

   int checks;
   int errors;
   int cyc;

   light_stand_ctrl #(
      .PWM_PERIOD      (10),
      .DUTY_L1         (2),
      .DUTY_L2         (5),
      .DUTY_L3         (7),
      .DUTY_L4         (10),
      .AUTO_OFF_PERIODS(3)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_btn_mode   (btnMode),
      .i_btn_off    (btnOff),
      .o_pwm        (pwm),
      .o_level      (level),
      .o_period_tick(periodTick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
      end
   endtask

   // cyc counts clocks since the last reset edge, so the DUT counter equals
   // cyc%10 and pwm at cyc reflects the count and duty held during cyc-1.
   task automatic applyStimulus(input int n, input int duty, input int lvl);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         checkOutput("level", 32'(level), 32'(lvl));
         checkOutput("pwm", 32'(pwm), 32'(((cyc - 1) % 10) < duty));
         checkOutput("tick", 32'(periodTick), 32'((cyc % 10) == 0));
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_pwm", 32'(pwm), 32'd0);
      checkOutput("rst_tick", 32'(periodTick), 32'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      reset   = 1'b1;
      btnMode = 1'b0;
      btnOff  = 1'b0;

      repeat (2) @(negedge clk);
      cyc = 0;
      checkResetState();
      reset = 1'b0;

      // Idle after reset: OFF, no pwm, tick every 10 clocks.
      applyStimulus(30, 0, 0);

      // Single mode pulse mid-period, then walk L1..L4..OFF.
      applyStimulus(4, 0, 0);
      btnMode = 1'b1;
      applyStimulus(1, 0, 1);
      btnMode = 1'b0;
      applyStimulus(5, 0, 1);
      applyStimulus(10, 2, 1);

      applyStimulus(4, 2, 1);
      btnMode = 1'b1;
      applyStimulus(1, 2, 2);
      btnMode = 1'b0;
      applyStimulus(5, 2, 2);
      applyStimulus(10, 5, 2);

      applyStimulus(4, 5, 2);
      btnMode = 1'b1;
      applyStimulus(1, 5, 3);
      btnMode = 1'b0;
      applyStimulus(5, 5, 3);
      applyStimulus(10, 7, 3);

      applyStimulus(4, 7, 3);
      btnMode = 1'b1;
      applyStimulus(1, 7, 4);
      btnMode = 1'b0;
      applyStimulus(5, 7, 4);
      applyStimulus(10, 10, 4);

      applyStimulus(4, 10, 4);
      btnMode = 1'b1;
      applyStimulus(1, 10, 0);
      btnMode = 1'b0;
      applyStimulus(5, 10, 0);
      applyStimulus(10, 0, 0);

      // Held mode input steps once per clock up to L3; then off+mode together.
      btnMode = 1'b1;
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 2);
      applyStimulus(1, 0, 3);
      btnMode = 1'b0;
      applyStimulus(7, 0, 3);
      applyStimulus(3, 7, 3);
      btnOff  = 1'b1;
      btnMode = 1'b1;
      applyStimulus(1, 7, 0);
      btnOff  = 1'b0;
      btnMode = 1'b0;
      applyStimulus(6, 0, 0);
      applyStimulus(10, 0, 0);

      // Auto-off at L2 after three idle full periods.
      btnMode = 1'b1;
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 2);
      btnMode = 1'b0;
      applyStimulus(8, 0, 2);
      applyStimulus(10, 5, 2);
      applyStimulus(10, 5, 2);
      applyStimulus(9, 5, 2);
      applyStimulus(1, 5, 0);
      applyStimulus(10, 0, 0);

      // Mode pulse on the expiry cycle suppresses auto-off and restarts idle.
      btnMode = 1'b1;
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 2);
      btnMode = 1'b0;
      applyStimulus(8, 0, 2);
      applyStimulus(10, 5, 2);
      applyStimulus(10, 5, 2);
      applyStimulus(9, 5, 2);
      btnMode = 1'b1;
      applyStimulus(1, 5, 3);
      btnMode = 1'b0;
      applyStimulus(10, 5, 3);
      applyStimulus(10, 7, 3);
      applyStimulus(10, 7, 3);
      applyStimulus(9, 7, 3);
      applyStimulus(1, 7, 0);

      // Reset in the middle of an L4 period.
      btnMode = 1'b1;
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 2);
      applyStimulus(1, 0, 3);
      applyStimulus(1, 0, 4);
      btnMode = 1'b0;
      applyStimulus(6, 0, 4);
      applyStimulus(4, 10, 4);
      reset = 1'b1;
      @(negedge clk);
      cyc = 0;
      checkResetState();
      reset = 1'b0;
      applyStimulus(10, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
